// File: rtl/game_collision_ctrl_if.sv
// Flappy run-control bus: scroller geometry in, run/halt handshake out.
// The master side drives the datapath inputs, the slave side is the controller.
interface game_collision_ctrl_if;
  logic       start_btn;
  logic       ack_btn;
  logic       move_tick;
  logic [9:0] pipe_L;
  logic [9:0] pipe_R;
  logic [9:0] gap_top;
  logic [9:0] gap_bot;
  logic [9:0] coin_L;
  logic [9:0] coin_R;
  logic [9:0] coin_Y;
  logic [9:0] bird_Y;
  logic       shift_coin;
  logic       Start;
  logic       Stop;
  logic       Ack;
  logic [3:0] Coins;
  logic       coin_visible;
  logic       q_idle;
  logic       q_run;
  logic       q_hit;
  logic       q_over;

  modport master (
    output start_btn, ack_btn, move_tick,
    output pipe_L, pipe_R, gap_top, gap_bot,
    output coin_L, coin_R, coin_Y, bird_Y,
    output shift_coin,
    input  Start, Stop, Ack, Coins, coin_visible,
    input  q_idle, q_run, q_hit, q_over
  );

  modport slave (
    input  start_btn, ack_btn, move_tick,
    input  pipe_L, pipe_R, gap_top, gap_bot,
    input  coin_L, coin_R, coin_Y, bird_Y,
    input  shift_coin,
    output Start, Stop, Ack, Coins, coin_visible,
    output q_idle, q_run, q_hit, q_over
  );
endinterface

// File: rtl/game_collision_ctrl.sv
// Flappy run-control FSM: pipe/ground collision, Start/Stop/Ack
// to the pipe scroller, and coin pickup counting.
module game_collision_ctrl #(
  parameter int BIRD_X      = 200,
  parameter int BIRD_W      = 20,
  parameter int BIRD_H      = 16,
  parameter int COIN_H      = 20,
  parameter int GROUND_Y    = 460,
  parameter int HIT_CONFIRM = 2
) (
  input  logic clk,
  input  logic reset,
  game_collision_ctrl_if.slave bus
);

  localparam int CW = $clog2(HIT_CONFIRM + 1);
  localparam logic [CW-1:0] HC = CW'(HIT_CONFIRM);

  localparam logic [10:0] BX_L = 11'(BIRD_X);
  localparam logic [10:0] BX_R = 11'(BIRD_X + BIRD_W - 1);
  localparam logic [10:0] BH_M = 11'(BIRD_H - 1);
  localparam logic [10:0] CH_M = 11'(COIN_H - 1);
  localparam logic [10:0] GND  = 11'(GROUND_Y);

  typedef enum logic [1:0] {
    QIdle,
    QRun,
    QHit,
    QOver
  } state_t;

  state_t        state_q, state_d;
  logic          start_q, start_d;
  logic          stop_q, stop_d;
  logic          ack_q, ack_d;
  logic [3:0]    coins_q, coins_d;
  logic          taken_q, taken_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // 11-bit geometry so bottom-edge sums never wrap
  logic [10:0] bird_t, bird_b;
  logic [10:0] coin_t, coin_b;
  logic        pipe_ov, ground_hit, coin_ov;

  assign bird_t = {1'b0, bus.bird_Y};
  assign bird_b = bird_t + BH_M;
  assign coin_t = {1'b0, bus.coin_Y};
  assign coin_b = coin_t + CH_M;

  assign pipe_ov = ({1'b0, bus.pipe_L} <= BX_R)
                && ({1'b0, bus.pipe_R} >= BX_L)
                && ((bird_t < {1'b0, bus.gap_top})
                 || (bird_b > {1'b0, bus.gap_bot}));

  assign ground_hit = bird_b >= GND;

  assign coin_ov = ({1'b0, bus.coin_L} <= BX_R)
                && ({1'b0, bus.coin_R} >= BX_L)
                && (coin_t <= bird_b)
                && (coin_b >= bird_t);

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    stop_d  = stop_q;
    ack_d   = 1'b0;
    coins_d = coins_q;
    taken_d = taken_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      QIdle: begin
        stop_d = 1'b0;
        if (bus.start_btn) begin
          start_d = 1'b1;
          coins_d = '0;
          taken_d = 1'b0;
          cnt_d   = '0;
          state_d = QRun;
        end
      end
      QRun: begin
        if (bus.move_tick) begin
          if (!pipe_ov)        cnt_d = '0;
          else if (cnt_q < HC) cnt_d = cnt_q + 1'b1;
        end
        if (coin_ov && !taken_q) begin
          taken_d = 1'b1;
          if (coins_q != 4'hF) coins_d = coins_q + 4'd1;
        end
        if (bus.shift_coin) taken_d = 1'b0;
        if (ground_hit || cnt_d == HC) begin
          stop_d  = 1'b1;
          state_d = QHit;
        end
      end
      QHit: begin
        stop_d  = 1'b1;
        state_d = QOver;
      end
      QOver: begin
        stop_d = 1'b1;
        if (bus.ack_btn) begin
          ack_d   = 1'b1;
          stop_d  = 1'b0;
          state_d = QIdle;
        end
      end
      default: state_d = QIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= QIdle;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      ack_q   <= 1'b0;
      coins_q <= '0;
      taken_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      ack_q   <= ack_d;
      coins_q <= coins_d;
      taken_q <= taken_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.Start        = start_q;
  assign bus.Stop         = stop_q;
  assign bus.Ack          = ack_q;
  assign bus.Coins        = coins_q;
  assign bus.coin_visible = ~taken_q;
  assign bus.q_idle       = (state_q == QIdle);
  assign bus.q_run        = (state_q == QRun);
  assign bus.q_hit        = (state_q == QHit);
  assign bus.q_over       = (state_q == QOver);

endmodule

// File: tb/tb_game_collision_ctrl.sv
// Directed bench for game_collision_ctrl: start, pipe/ground hits,
// coin counting with saturation, ack handshake and mid-game reset.
module tb_game_collision_ctrl;
  logic clk;
  logic reset;
  int   nvec;
  int   nerr;

  game_collision_ctrl_if bus ();

  game_collision_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic park();
    bus.start_btn  = 1'b0;
    bus.ack_btn    = 1'b0;
    bus.move_tick  = 1'b0;
    bus.shift_coin = 1'b0;
    bus.pipe_L     = 10'd600;
    bus.pipe_R     = 10'd650;
    bus.gap_top    = 10'd150;
    bus.gap_bot    = 10'd250;
    bus.coin_L     = 10'd700;
    bus.coin_R     = 10'd720;
    bus.coin_Y     = 10'd100;
    bus.bird_Y     = 10'd100;
  endtask

  task automatic go();
    bus.start_btn = 1'b1;
    tick();
    bus.start_btn = 1'b0;
  endtask

  task automatic crash();
    bus.bird_Y = 10'd445;
    tick();
    tick();
    bus.bird_Y = 10'd100;
  endtask

  task automatic ack();
    bus.ack_btn = 1'b1;
    tick();
    bus.ack_btn = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    park();
    reset = 1'b1;
    tick();
    tick();
    nvec++;
    if (bus.q_idle !== 1'b1 || bus.q_run !== 1'b0) begin
      nerr++;
      $display("FAIL rst_state got idle=%b run=%b exp 1 0", bus.q_idle, bus.q_run);
    end
    nvec++;
    if ({bus.Start, bus.Stop, bus.Ack} !== 3'b000) begin
      nerr++;
      $display("FAIL rst_ctl got %b exp 000", {bus.Start, bus.Stop, bus.Ack});
    end
    nvec++;
    if (bus.Coins !== 4'd0 || bus.coin_visible !== 1'b1) begin
      nerr++;
      $display("FAIL rst_coin got %0d/%b exp 0/1", bus.Coins, bus.coin_visible);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_start();
    go();
    nvec++;
    if (bus.Start !== 1'b1 || bus.q_run !== 1'b1) begin
      nerr++;
      $display("FAIL start_pulse got %b/%b exp 1/1", bus.Start, bus.q_run);
    end
    nvec++;
    if (bus.Stop !== 1'b0 || bus.Coins !== 4'd0) begin
      nerr++;
      $display("FAIL start_clr got %b/%0d exp 0/0", bus.Stop, bus.Coins);
    end
    tick();
    nvec++;
    if (bus.Start !== 1'b0 || bus.q_run !== 1'b1) begin
      nerr++;
      $display("FAIL start_once got %b/%b exp 0/1", bus.Start, bus.q_run);
    end
  endtask

  task automatic test_pipe_hit();
    bus.pipe_L = 10'd190;
    bus.pipe_R = 10'd251;
    bus.move_tick = 1'b1;
    tick();
    bus.move_tick = 1'b0;
    tick();
    nvec++;
    if (bus.q_run !== 1'b1) begin
      nerr++;
      $display("FAIL pipe_one_tick got run=%b exp 1", bus.q_run);
    end
    bus.move_tick = 1'b1;
    tick();
    bus.move_tick = 1'b0;
    nvec++;
    if (bus.q_hit !== 1'b1 || bus.Stop !== 1'b1) begin
      nerr++;
      $display("FAIL pipe_hit got hit=%b stop=%b exp 1 1", bus.q_hit, bus.Stop);
    end
    tick();
    nvec++;
    if (bus.q_over !== 1'b1 || bus.Stop !== 1'b1) begin
      nerr++;
      $display("FAIL pipe_over got over=%b stop=%b exp 1 1", bus.q_over, bus.Stop);
    end
    park();
  endtask

  task automatic test_ack_held();
    int acks;
    acks = 0;
    bus.ack_btn = 1'b1;
    tick();
    nvec++;
    if (bus.Ack !== 1'b1 || bus.Stop !== 1'b0 || bus.q_idle !== 1'b1) begin
      nerr++;
      $display("FAIL ack_edge got ack=%b stop=%b idle=%b exp 1 0 1", bus.Ack, bus.Stop, bus.q_idle);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.Ack === 1'b1) acks++;
    end
    bus.ack_btn = 1'b0;
    nvec++;
    if (acks !== 0 || bus.q_idle !== 1'b1) begin
      nerr++;
      $display("FAIL ack_single got extra=%0d idle=%b exp 0 1", acks, bus.q_idle);
    end
  endtask

  task automatic test_pipe_reset_cnt();
    go();
    bus.pipe_L = 10'd190;
    bus.pipe_R = 10'd251;
    bus.move_tick = 1'b1;
    tick();
    bus.pipe_L = 10'd600;
    bus.pipe_R = 10'd650;
    tick();
    bus.pipe_L = 10'd190;
    bus.pipe_R = 10'd251;
    tick();
    bus.move_tick = 1'b0;
    nvec++;
    if (bus.q_run !== 1'b1 || bus.Stop !== 1'b0) begin
      nerr++;
      $display("FAIL pipe_cnt_clr got run=%b stop=%b exp 1 0", bus.q_run, bus.Stop);
    end
    park();
    tick();
  endtask

  task automatic test_ground();
    bus.bird_Y = 10'd444;
    tick();
    tick();
    nvec++;
    if (bus.q_run !== 1'b1) begin
      nerr++;
      $display("FAIL ground_459 got run=%b exp 1", bus.q_run);
    end
    bus.bird_Y = 10'd445;
    tick();
    nvec++;
    if (bus.q_hit !== 1'b1 || bus.Stop !== 1'b1) begin
      nerr++;
      $display("FAIL ground_460 got hit=%b stop=%b exp 1 1", bus.q_hit, bus.Stop);
    end
    bus.bird_Y = 10'd100;
    tick();
    ack();
  endtask

  task automatic test_coin();
    go();
    bus.coin_L = 10'd205;
    bus.coin_R = 10'd225;
    bus.coin_Y = 10'd100;
    bus.bird_Y = 10'd110;
    repeat (10) tick();
    nvec++;
    if (bus.Coins !== 4'd1 || bus.coin_visible !== 1'b0) begin
      nerr++;
      $display("FAIL coin_take got %0d/%b exp 1/0", bus.Coins, bus.coin_visible);
    end
    bus.shift_coin = 1'b1;
    tick();
    nvec++;
    if (bus.Coins !== 4'd1 || bus.coin_visible !== 1'b1) begin
      nerr++;
      $display("FAIL coin_shift got %0d/%b exp 1/1", bus.Coins, bus.coin_visible);
    end
    tick();
    nvec++;
    if (bus.Coins !== 4'd2 || bus.coin_visible !== 1'b1) begin
      nerr++;
      $display("FAIL coin_same_cyc got %0d/%b exp 2/1", bus.Coins, bus.coin_visible);
    end
    repeat (13) tick();
    nvec++;
    if (bus.Coins !== 4'd15) begin
      nerr++;
      $display("FAIL coin_fill got %0d exp 15", bus.Coins);
    end
    repeat (3) tick();
    nvec++;
    if (bus.Coins !== 4'd15) begin
      nerr++;
      $display("FAIL coin_sat got %0d exp 15", bus.Coins);
    end
    park();
    crash();
    nvec++;
    if (bus.q_over !== 1'b1 || bus.Coins !== 4'd15) begin
      nerr++;
      $display("FAIL coin_hold got over=%b coins=%0d exp 1 15", bus.q_over, bus.Coins);
    end
    ack();
    go();
    nvec++;
    if (bus.Coins !== 4'd0 || bus.coin_visible !== 1'b1) begin
      nerr++;
      $display("FAIL coin_restart got %0d/%b exp 0/1", bus.Coins, bus.coin_visible);
    end
  endtask

  task automatic test_reset_mid();
    bus.coin_L = 10'd205;
    bus.coin_R = 10'd225;
    bus.bird_Y = 10'd110;
    tick();
    park();
    nvec++;
    if (bus.Coins !== 4'd1 || bus.q_run !== 1'b1) begin
      nerr++;
      $display("FAIL mid_pre got %0d/%b exp 1/1", bus.Coins, bus.q_run);
    end
    #2 reset = 1'b1;
    #1;
    nvec++;
    if (bus.q_idle !== 1'b1 || bus.Coins !== 4'd0 || bus.Ack !== 1'b0) begin
      nerr++;
      $display("FAIL mid_reset got idle=%b coins=%0d ack=%b exp 1 0 0", bus.q_idle, bus.Coins, bus.Ack);
    end
    tick();
    reset = 1'b0;
    tick();
    nvec++;
    if (bus.Ack !== 1'b0 || bus.Stop !== 1'b0 || bus.q_idle !== 1'b1) begin
      nerr++;
      $display("FAIL mid_after got ack=%b stop=%b idle=%b exp 0 0 1", bus.Ack, bus.Stop, bus.q_idle);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    reset = 1'b1;
    test_reset();
    test_start();
    test_pipe_hit();
    test_ack_held();
    test_pipe_reset_cnt();
    test_ground();
    test_coin();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
